// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter. It holds the fetch and data requester
// handshakes, the shared memory bus, and the timeout error reporting.
// The slave modport is the arbiter's view. The master modport is the
// surrounding core/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester (read-only)
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ready_o;
  logic              if_stallreq_o;

  // Data-access requester (read/write)
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ready_o;
  logic              mem_stallreq_o;

  // Shared single-port memory bus
  logic              bus_ce_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;

  // Sticky watchdog error
  logic              err_o;
  logic [ADDR_W-1:0] err_addr_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  bus_rdata_i, bus_ack_i,
    output if_rdata_o, if_ready_o, if_stallreq_o,
    output mem_rdata_o, mem_ready_o, mem_stallreq_o,
    output bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output err_o, err_addr_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output bus_rdata_i, bus_ack_i,
    input  if_rdata_o, if_ready_o, if_stallreq_o,
    input  mem_rdata_o, mem_ready_o, mem_stallreq_o,
    input  bus_ce_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  err_o, err_addr_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between the fetch port
// and the data port. Data normally wins ties. After MAX_MEM_STREAK consecutive
// data grants with fetch waiting, fetch gets the bus.
// The bus outputs are registered. Ready and read data are combinational
// from bus_ack_i.
// Optional feature ARB_TIMEOUT_EN: an ack watchdog. It completes a stuck access
// with 32'hDEAD_BEEF and records a sticky error. When the macro is not
// defined, the arbiter waits indefinitely and err_o/err_addr_o are held at 0.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_MEM_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   arb
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_IF  = 2'd1;
  localparam logic [1:0] BUSY_MEM = 2'd2;

  localparam int                  STREAK_W     = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX   = STREAK_W'(MAX_MEM_STREAK);
  localparam logic [DATA_W-1:0]   TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

  // Reject configurations the streak counter or the watchdog cannot represent
  if (MAX_MEM_STREAK < 1 || MAX_MEM_STREAK > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_MEM_STREAK must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]          state;
  logic [STREAK_W-1:0] streak;
  logic                grant_if;
  logic                grant_mem;
  logic                timeout;
  logic                done;
  logic [DATA_W-1:0]   resp_data;

  // Choose which requester is granted when the bus is idle
  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // leaves one unassigned would infer a latch.
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == IDLE) begin
      if (arb.mem_req_i && !(arb.if_req_i && streak == STREAK_MAX))
        grant_mem = 1'b1;
      else if (arb.if_req_i)
        grant_if = 1'b1;
    end
  end

  // Access completes on ack, or on watchdog expiry when ack never comes
  assign done      = (state != IDLE) && (arb.bus_ack_i || timeout);
  assign resp_data = arb.bus_ack_i ? arb.bus_rdata_i : TIMEOUT_DATA;

  assign arb.if_ready_o     = done && (state == BUSY_IF);
  assign arb.mem_ready_o    = done && (state == BUSY_MEM);
  assign arb.if_rdata_o     = arb.if_ready_o  ? resp_data : '0;
  assign arb.mem_rdata_o    = arb.mem_ready_o ? resp_data : '0;
  assign arb.if_stallreq_o  = arb.if_req_i  && !arb.if_ready_o;
  assign arb.mem_stallreq_o = arb.mem_req_i && !arb.mem_ready_o;

  // Sequence the state and launch or retire the registered bus transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments. That way every
    // register samples its inputs from before the clock edge.
    if (rst_i) begin
      state           <= IDLE;
      arb.bus_ce_o    <= 1'b0;
      arb.bus_we_o    <= 1'b0;
      arb.bus_addr_o  <= '0;
      arb.bus_wdata_o <= '0;
    end else if (grant_mem) begin
      state           <= BUSY_MEM;
      arb.bus_ce_o    <= 1'b1;
      arb.bus_we_o    <= arb.mem_we_i;
      arb.bus_addr_o  <= arb.mem_addr_i;
      arb.bus_wdata_o <= arb.mem_wdata_i;
    end else if (grant_if) begin
      state           <= BUSY_IF;
      arb.bus_ce_o    <= 1'b1;
      arb.bus_we_o    <= 1'b0;
      arb.bus_addr_o  <= arb.if_addr_i;
      arb.bus_wdata_o <= '0;
    end else if (done) begin
      state           <= IDLE;
      arb.bus_ce_o    <= 1'b0;
    end
  end

  // Count back-to-back data grants taken while fetch was kept waiting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      streak <= '0;
    else if (grant_if)
      streak <= '0;
    else if (grant_mem)
      streak <= arb.if_req_i ? streak + 1'b1 : '0;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0]  wait_cnt;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  assign timeout = (state != IDLE) && !arb.bus_ack_i &&
                   (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting for ack in the current access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      wait_cnt <= '0;
    else if (grant_if || grant_mem)
      wait_cnt <= '0;
    else if (state != IDLE)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Record the first watchdog expiry until the next reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (timeout && !err) begin
      err      <= 1'b1;
      err_addr <= arb.bus_addr_o;
    end
  end

  assign arb.err_o      = err;
  assign arb.err_addr_o = err_addr;
`else
  assign timeout        = 1'b0;
  assign arb.err_o      = 1'b0;
  assign arb.err_addr_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. It runs directed scenarios, then
// randomized traffic. Every cycle is compared against a transaction-level
// reference model with a behavioural memory that acks after a chosen latency.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int MAX_STREAK = 4;
  localparam int TMO        = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) arb_if ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_MEM_STREAK(MAX_STREAK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .arb   (arb_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the one transaction in flight, plus arbitration history
  bit          m_busy;
  owner_t      m_owner;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_err_addr;
  int          m_streak, m_age;
  bit          m_err;

  // Requesters and memory stimulus controls
  bit          if_active, if_dropped, mem_active, mem_dropped;
  logic [31:0] if_addr_r, mem_addr_r, mem_wdata_r;
  logic        mem_we_r;
  bit          rand_req, always_req, drop_en, stray_en, force_stray, rand_lat;
  int          fixed_lat, mem_lat, mem_cnt, seq_no;

  // Values observed in the last step, for directed checks
  logic        obs_ce, obs_we, obs_if_rdy, obs_mem_rdy, obs_if_stall, obs_mem_stall, obs_err;
  logic [31:0] obs_addr, obs_wdata, obs_if_rdata, obs_err_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = OWN_IF; m_we = 0; m_addr = '0; m_wdata = '0;
    m_streak = 0; m_age = 0; m_err = 0; m_err_addr = '0;
    mem_cnt = 0; mem_lat = fixed_lat;
  endtask

  // One clock cycle. It starts just after a rising edge: drive inputs, check
  // at the falling edge, then advance the model across the next rising edge.
  task automatic step();
    logic        ack, ce_was, tmo, done, e_if_rdy, e_mem_rdy;
    logic [31:0] rd, e_resp;
    arb_if.if_req_i    = if_active && !if_dropped;
    arb_if.if_addr_i   = if_addr_r;
    arb_if.mem_req_i   = mem_active && !mem_dropped;
    arb_if.mem_we_i    = mem_we_r;
    arb_if.mem_addr_i  = mem_addr_r;
    arb_if.mem_wdata_i = mem_wdata_r;
    ce_was = arb_if.bus_ce_o;
    ack = 1'b0; rd = '0;
    if (ce_was && mem_cnt == mem_lat) begin
      ack = 1'b1; rd = mem_val(arb_if.bus_addr_o);
    end else if (!ce_was && (force_stray || (stray_en && $urandom_range(0, 5) == 0))) begin
      ack = 1'b1; rd = $urandom;
    end
    arb_if.bus_ack_i   = ack;
    arb_if.bus_rdata_i = rd;

    @(negedge clk);
    tmo       = TMO_EN && m_busy && !ack && (m_age == TMO - 1);
    done      = m_busy && (ack || tmo);
    e_resp    = ack ? mem_val(m_addr) : 32'hDEAD_BEEF;
    e_if_rdy  = done && (m_owner == OWN_IF);
    e_mem_rdy = done && (m_owner == OWN_MEM);
    check("bus_ce", arb_if.bus_ce_o, m_busy);
    check("bus_we", arb_if.bus_we_o, m_we);
    check("bus_addr", arb_if.bus_addr_o, m_addr);
    check("bus_wdata", arb_if.bus_wdata_o, m_wdata);
    check("if_ready", arb_if.if_ready_o, e_if_rdy);
    check("mem_ready", arb_if.mem_ready_o, e_mem_rdy);
    check("if_rdata", arb_if.if_rdata_o, e_if_rdy ? e_resp : 32'h0);
    if (!(e_mem_rdy && m_we))
      check("mem_rdata", arb_if.mem_rdata_o, e_mem_rdy ? e_resp : 32'h0);
    check("if_stall", arb_if.if_stallreq_o, arb_if.if_req_i && !e_if_rdy);
    check("mem_stall", arb_if.mem_stallreq_o, arb_if.mem_req_i && !e_mem_rdy);
    check("err", arb_if.err_o, m_err);
    check("err_addr", arb_if.err_addr_o, m_err_addr);
    obs_ce = arb_if.bus_ce_o; obs_we = arb_if.bus_we_o; obs_addr = arb_if.bus_addr_o;
    obs_wdata = arb_if.bus_wdata_o; obs_if_rdy = arb_if.if_ready_o;
    obs_mem_rdy = arb_if.mem_ready_o; obs_if_rdata = arb_if.if_rdata_o;
    obs_if_stall = arb_if.if_stallreq_o; obs_mem_stall = arb_if.mem_stallreq_o;
    obs_err = arb_if.err_o; obs_err_addr = arb_if.err_addr_o;

    @(posedge clk);
    if (m_busy) begin
      if (tmo && !m_err) begin m_err = 1; m_err_addr = m_addr; end
      if (done) m_busy = 0;
      else      m_age++;
    end else if (arb_if.mem_req_i && !(arb_if.if_req_i && m_streak == MAX_STREAK)) begin
      m_busy = 1; m_age = 0; m_owner = OWN_MEM; m_we = arb_if.mem_we_i;
      m_addr = arb_if.mem_addr_i; m_wdata = arb_if.mem_wdata_i;
      m_streak = arb_if.if_req_i ? m_streak + 1 : 0;
    end else if (arb_if.if_req_i) begin
      m_busy = 1; m_age = 0; m_owner = OWN_IF; m_we = 0;
      m_addr = arb_if.if_addr_i; m_wdata = '0; m_streak = 0;
    end
    if (!ce_was) begin
      mem_cnt = 0;
      mem_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else begin
      mem_cnt++;
    end
    if (e_if_rdy)  begin if_active = 0;  if_dropped = 0;  end
    if (e_mem_rdy) begin mem_active = 0; mem_dropped = 0; end
    if (rand_req) begin
      if (!if_active && (always_req || $urandom_range(0, 2) == 0)) begin
        if_active = 1;
        if_addr_r = always_req ? 32'h1000 + 32'(seq_no * 4) : $urandom;
        seq_no++;
      end
      if (!mem_active && (always_req || $urandom_range(0, 2) == 0)) begin
        mem_active  = 1;
        mem_we_r    = always_req ? 1'b0 : 1'($urandom_range(0, 1));
        mem_addr_r  = always_req ? 32'h8000 + 32'(seq_no * 4) : $urandom;
        mem_wdata_r = $urandom;
        seq_no++;
      end
      if (drop_en) begin
        if (if_active && !if_dropped && m_busy && m_owner == OWN_IF && $urandom_range(0, 9) == 0)
          if_dropped = 1;
        if (mem_active && !mem_dropped && m_busy && m_owner == OWN_MEM && $urandom_range(0, 9) == 0)
          mem_dropped = 1;
      end
    end
    #1;
  endtask

  task automatic drain(input string tag);
    bit idle = 0;
    rand_req = 0; always_req = 0; drop_en = 0; stray_en = 0; rand_lat = 0; fixed_lat = 1;
    for (int i = 0; i < 40 && !idle; i++) begin
      step();
      idle = !if_active && !mem_active && !obs_ce;
    end
    check(tag, idle, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   gq[$];
    bit   exp_seq[6];
    bit   prev_ce;
    int   cnt_a, cnt_b, cnt_c;

    if_active = 0; if_dropped = 0; mem_active = 0; mem_dropped = 0;
    if_addr_r = '0; mem_addr_r = '0; mem_wdata_r = '0; mem_we_r = 0;
    rand_req = 0; always_req = 0; drop_en = 0; stray_en = 0; force_stray = 0;
    rand_lat = 0; fixed_lat = 1; seq_no = 0;
    arb_if.if_req_i = 0; arb_if.if_addr_i = '0; arb_if.mem_req_i = 0; arb_if.mem_we_i = 0;
    arb_if.mem_addr_i = '0; arb_if.mem_wdata_i = '0; arb_if.bus_rdata_i = '0; arb_if.bus_ack_i = 0;
    model_reset();

    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_ce", arb_if.bus_ce_o, 1'b0);
    check("rst_we", arb_if.bus_we_o, 1'b0);
    check("rst_addr", arb_if.bus_addr_o, 32'h0);
    check("rst_wdata", arb_if.bus_wdata_o, 32'h0);
    check("rst_err", arb_if.err_o, 1'b0);
    check("rst_err_addr", arb_if.err_addr_o, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) step();

    // Fetch only: ce at N+1, ready with 0x13 at N+2
    fixed_lat = 1; if_active = 1; if_addr_r = 32'h100;
    step();
    check("t1_stall_n", obs_if_stall, 1'b1);
    check("t1_ce_n", obs_ce, 1'b0);
    step();
    check("t1_ce_n1", obs_ce, 1'b1);
    check("t1_stall_n1", obs_if_stall, 1'b1);
    check("t1_rdy_n1", obs_if_rdy, 1'b0);
    step();
    check("t1_rdy_n2", obs_if_rdy, 1'b1);
    check("t1_rdata_n2", obs_if_rdata, 32'h13);
    step();
    check("t1_ce_after", obs_ce, 1'b0);

    // Data write with ack three cycles after ce
    fixed_lat = 3; mem_active = 1; mem_we_r = 1;
    mem_addr_r = 32'h2000; mem_wdata_r = 32'hCAFE_F00D;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (8) begin
      step();
      if (obs_ce && obs_we && obs_addr == 32'h2000 && obs_wdata == 32'hCAFE_F00D) cnt_a++;
      if (obs_mem_rdy) cnt_b++;
      if (obs_mem_stall) cnt_c++;
    end
    check("t2_we_cycles", cnt_a, 4);
    check("t2_ready_pulses", cnt_b, 1);
    check("t2_stall_cycles", cnt_c, 4);

    // Both requests held continuously: four data grants, then one fetch grant
    fixed_lat = 0; rand_req = 1; always_req = 1; prev_ce = 0;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 30 && gq.size() < 6; i++) begin
      step();
      if (obs_ce && !prev_ce) gq.push_back(obs_addr >= 32'h8000);
      prev_ce = obs_ce;
    end
    check("t3_grant_count", gq.size(), 6);
    for (int k = 0; k < gq.size() && k < 6; k++)
      check($sformatf("t3_grant%0d", k), gq[k], exp_seq[k]);
    drain("t3_drain");

    // Reset while in BUSY_MEM: bus clears at once, no ready, then normal service
    fixed_lat = 6; mem_active = 1; mem_we_r = 1;
    mem_addr_r = 32'h3000; mem_wdata_r = 32'h1234_5678;
    repeat (3) step();
    check("t4_busy_before", obs_ce, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_ce", arb_if.bus_ce_o, 1'b0);
    check("t4_rst_we", arb_if.bus_we_o, 1'b0);
    check("t4_rst_addr", arb_if.bus_addr_o, 32'h0);
    check("t4_rst_wdata", arb_if.bus_wdata_o, 32'h0);
    check("t4_rst_ready", arb_if.mem_ready_o, 1'b0);
    #1 rst = 1'b0;
    fixed_lat = 1;
    model_reset();
    cnt_a = 0;
    for (int i = 0; i < 10 && mem_active; i++) begin
      step();
      if (obs_mem_rdy) cnt_a++;
    end
    check("t4_serviced", cnt_a, 1);

    // Ack while idle is ignored
    force_stray = 1;
    step();
    force_stray = 0;
    check("t5_if_rdy", obs_if_rdy, 1'b0);
    check("t5_mem_rdy", obs_mem_rdy, 1'b0);
    step();
    check("t5_ce", obs_ce, 1'b0);

    // Fetch request dropped while busy still completes with a ready pulse
    fixed_lat = 2; if_active = 1; if_addr_r = 32'h500;
    step(); step();
    if_dropped = 1;
    cnt_a = 0;
    repeat (6) begin
      step();
      if (obs_if_rdy) cnt_a++;
    end
    check("t6_drop_ready", cnt_a, 1);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no ack on fetch 0x40, completes after eight busy cycles
    fixed_lat = 1000; if_active = 1; if_addr_r = 32'h40;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20 && cnt_b == 0; i++) begin
      step();
      if (obs_ce) cnt_a++;
      if (obs_if_rdy) begin
        cnt_b++;
        check("t7_rdata", obs_if_rdata, 32'hDEAD_BEEF);
      end
    end
    check("t7_timed_out", cnt_b, 1);
    check("t7_busy_cycles", cnt_a, 8);
    fixed_lat = 1;
    step();
    check("t7_err", obs_err, 1'b1);
    check("t7_err_addr", obs_err_addr, 32'h40);
    check("t7_ce_dropped", obs_ce, 1'b0);
`else
    check("t7_err_tied", arb_if.err_o, 1'b0);
`endif

    // Randomized traffic with drops, stray acks and variable latency
    rand_req = 1; drop_en = 1; stray_en = 1; rand_lat = 1;
    repeat (800) step();
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
